sha1_msg_sched_stream: RTL and testbench
========================================

// Module: sha1_msg_sched_stream
// PURPOSE
//  Streaming SHA-1/SHA-0 message scheduler. Accepts one 512-bit block (W[0..15]) over a valid/ready handshake.
//  Emits the full schedule W[0..ROUNDS-1], WPC words per beat, over a valid/ready output with round index and last flag.
//  Sits between the block padder and the compression round engine; generalises the single-word extend stage.
// PARAMETERS
//  WORD_W   32   schedule word width
//  WPC      1    words emitted per beat; legal 1, 2, 4 (must divide ROUNDS)
//  ROUNDS   80   schedule length (words)
//  IDX_W    7    width of round index, >= clog2(ROUNDS)
// PORTS
//  clk        in   1             clock, rising edge
//  rst_n      in   1             asynchronous active-low reset
//  flush      in   1             sync abort of current block, highest priority after reset
//  blk_valid  in   1             input block valid
//  blk_ready  out  1             input block ready
//  blk_data   in   16*WORD_W     block; W[0] in MSBs [511:480], W[15] in LSBs
//  blk_sha0   in   1             1 = SHA-0 expansion (no rotate); sampled with block
//  w_valid    out  1             schedule beat valid
//  w_ready    in   1             downstream ready
//  w_data     out  WPC*WORD_W    W[w_idx] in MSBs ... W[w_idx+WPC-1] in LSBs
//  w_idx      out  IDX_W         round index of MSB word of beat
//  w_last     out  1             beat contains W[ROUNDS-1]
// BEHAVIOUR
//  - Reset (async): state=IDLE, w_valid=0, w_idx=0, w_last=0, w_data=0, window=0, mode=SHA-1; blk_ready=1 out of reset.
//  - States: IDLE (no block held) / EMIT (window holds W[t..t+15], t=w_idx).
//  - blk_ready = (state==IDLE) | (w_valid & w_ready & w_last); combinational path from w_ready.
//  - Accept (blk_valid&blk_ready): window<=blk_data, mode<=blk_sha0, w_idx<=0, state<=EMIT; w_valid=1 the next cycle (1-cycle latency).
//  - w_data = top WPC words of window; w_last = (w_idx == ROUNDS-WPC). Registered, not recomputed from w_ready.
//  - Beat handshake (w_valid&w_ready), not last: window shifts left WPC words, WPC new words fill LSBs.
//    w_idx += WPC.
//  - New word j (0..WPC-1), window index k=16+j:
//    x = win[k-3]^win[k-8]^win[k-14]^win[k-16]; W = mode ? x : rotl1(x).
//    For WPC=4, j=3 uses freshly computed j=0 as win[k-3] (intra-beat chain, combinational).
//  - Last beat handshake: accept a pending block the same cycle if blk_valid (no bubble); else IDLE, w_valid=0.
//  - Stall (w_valid & !w_ready): w_data, w_idx, w_last, window held stable; no state change.
//  - flush=1: next cycle state=IDLE, w_valid=0, w_idx=0; block input ignored that cycle (blk_ready=0 while flush=1).
//  - Reset mid-block: abandons block immediately; no partial beats after deassert.
//  - w_idx never wraps past ROUNDS-WPC; the counter is only reloaded on accept.
// STRUCTURE
//  - Package sha1_pkg: SHA1_WORD_W=32, SHA1_BLK_WORDS=16, SHA1_ROUNDS=80, sched_state_e {IDLE,EMIT}.
//    Also function rotl1(). Shared with the round engine.
//  - Sub-module sha1_w_expand_comb #(WPC): purely combinational, window+mode -> WPC new words.
//  - Top: FSM, index counter, window register, handshake logic.
//  - Elaboration assertion on WPC legality and ROUNDS%WPC==0.
// TESTING
//  1 WPC=1, SHA-1, "abc" block (W0=0x61626380, W15=0x00000018, rest 0), w_ready=1:
//    80 beats idx 0..79; W16=0xC2C4C700, W17=0, W18=0x00000030; w_last only at idx 79.
//  2 Same block, blk_sha0=1: W16=0x61626380, W18=0x00000018; then a SHA-1 block: mode re-sampled, W16=0xC2C4C700.
//  3 Random w_ready (~40% low): w_data/w_idx stable during every stall; stream equals reference model; 80 beats total.
//  4 Two blocks back-to-back, blk_valid held: 2nd accepted in the idx-79 handshake cycle.
//    Its W0 appears next cycle; 160 consecutive valid beats.
//  5 flush at idx 40 (and separately rst_n low at idx 40): w_valid=0 next cycle, blk_ready=1.
//    A new block restarts at idx 0 with correct W0.
//  6 WPC=4, "abc": 20 beats; beat 4 w_idx=16, w_data={0xC2C4C700,0,0x00000030,W19}; w_last at idx 76; matches model.

Source files
------------

// File: rtl/sha1_pkg.sv
// Shared SHA-1 constants, schedule FSM encoding and word helpers.
// Used by the message scheduler and the compression round engine.
package sha1_pkg;

    localparam int SHA1_WORD_W    = 32;
    localparam int SHA1_BLK_WORDS = 16;
    localparam int SHA1_ROUNDS    = 80;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } sched_state_e;

    function automatic logic [SHA1_WORD_W-1:0] rotl1(input logic [SHA1_WORD_W-1:0] x);
        return {x[SHA1_WORD_W-2:0], x[SHA1_WORD_W-1]};
    endfunction

endpackage

// File: rtl/sha1_w_expand_comb.sv
// Combinational schedule expansion: from the 16-word window W[t..t+15]
// produce the next WPC words W[t+16..t+16+WPC-1].
module sha1_w_expand_comb
    import sha1_pkg::*;
#(
    parameter int WORD_W = SHA1_WORD_W,
    parameter int WPC    = 1
) (
    input  logic [SHA1_BLK_WORDS*WORD_W-1:0] window,
    input  logic                             mode,
    output logic [WPC*WORD_W-1:0]            new_words
);

    logic [WORD_W-1:0] ext [0:SHA1_BLK_WORDS+WPC-1];
    logic [WORD_W-1:0] x   [0:WPC-1];

    // ext[0] is the oldest word (window MSBs); ext[16+j] are the fresh words,
    // so a tap beyond the window naturally chains to an earlier fresh word.
    always_comb begin
        for (int i = 0; i < SHA1_BLK_WORDS + WPC; i++) begin
            ext[i] = '0;
        end
        for (int j = 0; j < WPC; j++) begin
            x[j] = '0;
        end
        new_words = '0;
        for (int i = 0; i < SHA1_BLK_WORDS; i++) begin
            ext[i] = window[(SHA1_BLK_WORDS-1-i)*WORD_W +: WORD_W];
        end
        for (int j = 0; j < WPC; j++) begin
            x[j] = ext[13+j] ^ ext[8+j] ^ ext[2+j] ^ ext[j];
            ext[SHA1_BLK_WORDS+j] = mode ? x[j] : {x[j][WORD_W-2:0], x[j][WORD_W-1]};
        end
        for (int j = 0; j < WPC; j++) begin
            new_words[(WPC-1-j)*WORD_W +: WORD_W] = ext[SHA1_BLK_WORDS+j];
        end
    end

endmodule

// File: rtl/sha1_msg_sched_stream.sv
// Streaming SHA-1/SHA-0 message scheduler: takes one 512-bit block and
// emits W[0..ROUNDS-1], WPC words per beat, with round index and last flag.
module sha1_msg_sched_stream
    import sha1_pkg::*;
#(
    parameter int WORD_W = SHA1_WORD_W,
    parameter int WPC    = 1,
    parameter int ROUNDS = SHA1_ROUNDS,
    parameter int IDX_W  = 7
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic                             blk_valid,
    output logic                             blk_ready,
    input  logic [SHA1_BLK_WORDS*WORD_W-1:0] blk_data,
    input  logic                             blk_sha0,
    output logic                             w_valid,
    input  logic                             w_ready,
    output logic [WPC*WORD_W-1:0]            w_data,
    output logic [IDX_W-1:0]                 w_idx,
    output logic                             w_last,
    output logic                             fsm_state
);

    localparam int WIN_W  = SHA1_BLK_WORDS * WORD_W;
    localparam int BEAT_W = WPC * WORD_W;
    localparam logic [IDX_W-1:0] IDX_STEP = IDX_W'(WPC);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ROUNDS - WPC);

    if (!(WPC == 1 || WPC == 2 || WPC == 4) || (ROUNDS % WPC) != 0
        || ROUNDS < SHA1_BLK_WORDS || (1 << IDX_W) < ROUNDS) begin : g_bad_params
        $error("sha1_msg_sched_stream: illegal WPC/ROUNDS/IDX_W combination");
    end

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high. w_valid never depends on w_ready; blk_ready does, so a
    // new block can be taken in the same cycle the last beat leaves.
    sched_state_e         state;
    logic [WIN_W-1:0]     window;
    logic                 mode;
    logic [BEAT_W-1:0]    new_words;
    logic                 beat;
    logic                 accept;

    assign beat      = w_valid & w_ready;
    assign blk_ready = ~flush & ((state == IDLE) | (beat & w_last));
    assign accept    = blk_valid & blk_ready;
    assign w_data    = window[WIN_W-1 -: BEAT_W];
    assign fsm_state = state;

    sha1_w_expand_comb #(
        .WORD_W (WORD_W),
        .WPC    (WPC)
    ) u_expand (
        .window    (window),
        .mode      (mode),
        .new_words (new_words)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            w_valid <= 1'b0;
            w_idx   <= '0;
            w_last  <= 1'b0;
            window  <= '0;
            mode    <= 1'b0;
        end else if (flush) begin
            state   <= IDLE;
            w_valid <= 1'b0;
            w_idx   <= '0;
            w_last  <= 1'b0;
        end else if (accept) begin
            state   <= EMIT;
            w_valid <= 1'b1;
            window  <= blk_data;
            mode    <= blk_sha0;
            w_idx   <= '0;
            w_last  <= (IDX_LAST == '0);
        end else if (beat) begin
            if (w_last) begin
                state   <= IDLE;
                w_valid <= 1'b0;
            end else begin
                window <= {window[WIN_W-BEAT_W-1:0], new_words};
                w_idx  <= w_idx + IDX_STEP;
                w_last <= ((w_idx + IDX_STEP) == IDX_LAST);
            end
        end
    end

endmodule

// File: tb/tb_sha1_msg_sched_stream.sv
// Directed bench for the streaming SHA-1 scheduler: WPC=1 and WPC=4 instances,
// hand-computed schedule words plus an independent recurrence model.
module tb_sha1_msg_sched_stream;

    logic clk;
    logic rst_n;

    logic         flush1, blk_valid1, blk_ready1, blk_sha0_1, w_valid1, w_ready1, w_last1, st1;
    logic [511:0] blk_data1;
    logic [31:0]  w_data1;
    logic [6:0]   w_idx1;

    logic         flush4, blk_valid4, blk_ready4, blk_sha0_4, w_valid4, w_ready4, w_last4, st4;
    logic [511:0] blk_data4;
    logic [127:0] w_data4;
    logic [6:0]   w_idx4;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0]  exp_q[$];
    logic [127:0] got_d [0:199];
    logic [6:0]   got_i [0:199];
    logic         got_l [0:199];
    int           got_n;

    logic [511:0] abc_blk;

    sha1_msg_sched_stream #(.WPC(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush1),
        .blk_valid(blk_valid1), .blk_ready(blk_ready1), .blk_data(blk_data1), .blk_sha0(blk_sha0_1),
        .w_valid(w_valid1), .w_ready(w_ready1), .w_data(w_data1), .w_idx(w_idx1), .w_last(w_last1),
        .fsm_state(st1)
    );

    sha1_msg_sched_stream #(.WPC(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush4),
        .blk_valid(blk_valid4), .blk_ready(blk_ready4), .blk_data(blk_data4), .blk_sha0(blk_sha0_4),
        .w_valid(w_valid4), .w_ready(w_ready4), .w_data(w_data4), .w_idx(w_idx4), .w_last(w_last4),
        .fsm_state(st4)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    task automatic model_block(input logic [511:0] blk, input logic sha0);
        logic [31:0] w [0:79];
        logic [31:0] x;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 80; t++) begin
            x = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
            w[t] = sha0 ? x : {x[30:0], x[31]};
        end
        for (int t = 0; t < 80; t++) exp_q.push_back(w[t]);
    endtask

    // ---------------- drivers (called at a negedge, return at a negedge) ----------------
    task automatic send_block(input int which, input logic [511:0] blk, input logic sha0);
        bit got;
        got = 1'b0;
        if (which == 1) begin
            blk_data1 = blk; blk_sha0_1 = sha0; blk_valid1 = 1'b1;
        end else begin
            blk_data4 = blk; blk_sha0_4 = sha0; blk_valid4 = 1'b1;
        end
        for (int i = 0; i < 200 && !got; i++) begin
            #1;
            got = (which == 1) ? (blk_ready1 === 1'b1) : (blk_ready4 === 1'b1);
            @(negedge clk);
        end
        blk_valid1 = 1'b0;
        blk_valid4 = 1'b0;
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: blk_ready never 1 for dut%0d, required 1", which);
        end
    endtask

    task automatic collect(input int which, input int n);
        got_n = 0;
        w_ready1 = 1'b1;
        w_ready4 = 1'b1;
        for (int c = 0; c < 1000 && got_n < n; c++) begin
            #1;
            if (which == 1 && w_valid1 === 1'b1) begin
                got_d[got_n] = {96'd0, w_data1}; got_i[got_n] = w_idx1; got_l[got_n] = w_last1; got_n++;
            end else if (which == 4 && w_valid4 === 1'b1) begin
                got_d[got_n] = w_data4; got_i[got_n] = w_idx4; got_l[got_n] = w_last4; got_n++;
            end
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_cmp++;
        if ({w_valid1, w_idx1, w_last1, w_data1, blk_ready1, st1} !== {1'b0, 7'd0, 1'b0, 32'd0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL reset_dut1: got v=%b idx=%0d last=%b data=%h rdy=%b st=%b, required 0 0 0 0 1 0",
                     w_valid1, w_idx1, w_last1, w_data1, blk_ready1, st1);
        end
        n_cmp++;
        if ({w_valid4, w_data4, blk_ready4} !== {1'b0, 128'd0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_dut4: got v=%b data=%h rdy=%b, required 0 0 1", w_valid4, w_data4, blk_ready4);
        end
    endtask

    task automatic test_sha1_abc();
        int errs;
        int lasts;
        exp_q.delete();
        model_block(abc_blk, 1'b0);
        send_block(1, abc_blk, 1'b0);
        #1;
        n_cmp++;
        if (w_valid1 !== 1'b1 || w_idx1 !== 7'd0 || w_data1 !== 32'h61626380) begin
            n_err++;
            $display("FAIL abc_first_beat: got v=%b idx=%0d data=%h, required 1 0 61626380", w_valid1, w_idx1, w_data1);
        end
        collect(1, 80);
        n_cmp++;
        if (got_n != 80) begin n_err++; $display("FAIL abc_count: got %0d beats, required 80", got_n); end
        n_cmp++;
        if (got_d[16][31:0] !== 32'hC2C4C700) begin n_err++; $display("FAIL abc_w16: got %h, required c2c4c700", got_d[16][31:0]); end
        n_cmp++;
        if (got_d[17][31:0] !== 32'h0) begin n_err++; $display("FAIL abc_w17: got %h, required 00000000", got_d[17][31:0]); end
        n_cmp++;
        if (got_d[18][31:0] !== 32'h30) begin n_err++; $display("FAIL abc_w18: got %h, required 00000030", got_d[18][31:0]); end
        errs = 0;
        lasts = 0;
        for (int i = 0; i < 80; i++) begin
            if (got_d[i][31:0] !== exp_q[i] || got_i[i] !== 7'(i)) errs++;
            if (got_l[i] === 1'b1) lasts++;
        end
        n_cmp++;
        if (errs != 0) begin n_err++; $display("FAIL abc_stream: got %0d wrong words/indices, required 0", errs); end
        n_cmp++;
        if (lasts != 1 || got_l[79] !== 1'b1) begin
            n_err++;
            $display("FAIL abc_last: got %0d last flags (idx79=%b), required 1 at idx 79", lasts, got_l[79]);
        end
        #1;
        n_cmp++;
        if (w_valid1 !== 1'b0 || blk_ready1 !== 1'b1) begin
            n_err++;
            $display("FAIL abc_idle_after: got v=%b rdy=%b, required 0 1", w_valid1, blk_ready1);
        end
        @(negedge clk);
    endtask

    task automatic test_sha0_then_sha1();
        int errs;
        exp_q.delete();
        model_block(abc_blk, 1'b1);
        send_block(1, abc_blk, 1'b1);
        collect(1, 80);
        n_cmp++;
        if (got_d[16][31:0] !== 32'h61626380) begin n_err++; $display("FAIL sha0_w16: got %h, required 61626380", got_d[16][31:0]); end
        n_cmp++;
        if (got_d[18][31:0] !== 32'h18) begin n_err++; $display("FAIL sha0_w18: got %h, required 00000018", got_d[18][31:0]); end
        errs = 0;
        for (int i = 0; i < 80; i++) if (got_d[i][31:0] !== exp_q[i]) errs++;
        n_cmp++;
        if (errs != 0 || got_n != 80) begin n_err++; $display("FAIL sha0_stream: got %0d wrong of %0d beats, required 0 of 80", errs, got_n); end
        @(negedge clk);
        send_block(1, abc_blk, 1'b0);
        collect(1, 80);
        n_cmp++;
        if (got_d[16][31:0] !== 32'hC2C4C700) begin n_err++; $display("FAIL sha1_resample_w16: got %h, required c2c4c700", got_d[16][31:0]); end
        @(negedge clk);
    endtask

    task automatic test_random_stall();
        logic [511:0] blk;
        logic [31:0]  pd;
        logic [31:0]  e;
        logic [6:0]   pi;
        bit           stalled;
        int           beats;
        int           stall_errs;
        int           data_errs;
        for (int i = 0; i < 16; i++) blk[511-32*i -: 32] = $urandom;
        exp_q.delete();
        model_block(blk, 1'b0);
        send_block(1, blk, 1'b0);
        beats = 0; stalled = 1'b0; stall_errs = 0; data_errs = 0; pd = '0; pi = '0;
        for (int c = 0; c < 2000 && beats < 80; c++) begin
            w_ready1 = ($urandom_range(0, 99) >= 40);
            #1;
            if (stalled && (w_data1 !== pd || w_idx1 !== pi)) stall_errs++;
            stalled = (w_valid1 === 1'b1) && !w_ready1;
            pd = w_data1;
            pi = w_idx1;
            if (w_valid1 === 1'b1 && w_ready1) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
                if (w_data1 !== e) data_errs++;
                beats++;
            end
            @(negedge clk);
        end
        w_ready1 = 1'b1;
        n_cmp++;
        if (stall_errs != 0) begin n_err++; $display("FAIL stall_stable: got %0d unstable stall cycles, required 0", stall_errs); end
        n_cmp++;
        if (data_errs != 0) begin n_err++; $display("FAIL stall_stream: got %0d wrong words, required 0", data_errs); end
        n_cmp++;
        if (beats != 80) begin n_err++; $display("FAIL stall_count: got %0d beats, required 80", beats); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [511:0] blk_b;
        logic [31:0]  e;
        logic [6:0]   acc_idx;
        logic         acc_last;
        int           beats;
        int           gaps;
        int           b_acc;
        int           data_errs;
        for (int i = 0; i < 16; i++) blk_b[511-32*i -: 32] = 32'h0101_0101 * (i + 3);
        exp_q.delete();
        model_block(abc_blk, 1'b0);
        model_block(blk_b, 1'b0);
        w_ready1 = 1'b1;
        send_block(1, abc_blk, 1'b0);
        blk_data1 = blk_b; blk_sha0_1 = 1'b0; blk_valid1 = 1'b1;
        beats = 0; gaps = 0; b_acc = 0; data_errs = 0; acc_idx = '0; acc_last = 1'b0;
        for (int c = 0; c < 400 && beats < 160; c++) begin
            #1;
            if (w_valid1 === 1'b1) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
                if (w_data1 !== e) data_errs++;
                beats++;
            end else gaps++;
            if (blk_valid1 && blk_ready1 === 1'b1) begin
                acc_idx = w_idx1; acc_last = w_last1; b_acc++;
            end
            @(negedge clk);
            if (b_acc > 0) blk_valid1 = 1'b0;
        end
        blk_valid1 = 1'b0;
        n_cmp++;
        if (beats != 160 || gaps != 0) begin n_err++; $display("FAIL b2b_continuous: got %0d beats %0d gaps, required 160 0", beats, gaps); end
        n_cmp++;
        if (b_acc != 1 || acc_idx !== 7'd79 || acc_last !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_accept_point: got %0d accepts at idx %0d last=%b, required 1 at idx 79 last=1", b_acc, acc_idx, acc_last);
        end
        n_cmp++;
        if (data_errs != 0) begin n_err++; $display("FAIL b2b_stream: got %0d wrong words, required 0", data_errs); end
        #1;
        n_cmp++;
        if (w_valid1 !== 1'b0) begin n_err++; $display("FAIL b2b_end: got w_valid=%b, required 0", w_valid1); end
        @(negedge clk);
    endtask

    task automatic test_abort(input bit use_reset);
        logic [511:0] blk_c;
        bit found;
        int errs;
        for (int i = 0; i < 16; i++) blk_c[511-32*i -: 32] = (i == 0) ? 32'hDEADBEEF : 32'h1357_9BDF ^ i;
        send_block(1, abc_blk, 1'b0);
        w_ready1 = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            #1;
            if (w_idx1 === 7'd40) found = 1'b1;
            else @(negedge clk);
        end
        n_cmp++;
        if (!found) begin n_err++; $display("FAIL abort_reach_40: idx 40 never seen, required within 200 cycles"); end
        if (use_reset) begin
            rst_n = 1'b0;
            #1;
            n_cmp++;
            if (w_valid1 !== 1'b0 || w_idx1 !== 7'd0 || w_data1 !== 32'd0) begin
                n_err++;
                $display("FAIL reset_mid: got v=%b idx=%0d data=%h, required 0 0 0", w_valid1, w_idx1, w_data1);
            end
            @(negedge clk);
            rst_n = 1'b1;
        end else begin
            flush1 = 1'b1;
            #1;
            n_cmp++;
            if (blk_ready1 !== 1'b0) begin n_err++; $display("FAIL flush_blk_ready: got %b during flush, required 0", blk_ready1); end
            @(negedge clk);
            flush1 = 1'b0;
        end
        #1;
        n_cmp++;
        if (w_valid1 !== 1'b0 || w_idx1 !== 7'd0 || blk_ready1 !== 1'b1) begin
            n_err++;
            $display("FAIL abort_after(%0d): got v=%b idx=%0d rdy=%b, required 0 0 1", use_reset, w_valid1, w_idx1, blk_ready1);
        end
        @(negedge clk);
        exp_q.delete();
        model_block(blk_c, 1'b0);
        send_block(1, blk_c, 1'b0);
        collect(1, 80);
        n_cmp++;
        if (got_i[0] !== 7'd0 || got_d[0][31:0] !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL abort_restart(%0d): got idx=%0d data=%h, required 0 deadbeef", use_reset, got_i[0], got_d[0][31:0]);
        end
        errs = 0;
        for (int i = 0; i < 80; i++) if (got_d[i][31:0] !== exp_q[i]) errs++;
        n_cmp++;
        if (errs != 0 || got_n != 80) begin n_err++; $display("FAIL abort_stream(%0d): got %0d wrong of %0d, required 0 of 80", use_reset, errs, got_n); end
        @(negedge clk);
    endtask

    task automatic test_wpc4();
        logic [127:0] e;
        int errs;
        int lasts;
        exp_q.delete();
        model_block(abc_blk, 1'b0);
        send_block(4, abc_blk, 1'b0);
        collect(4, 20);
        n_cmp++;
        if (got_n != 20) begin n_err++; $display("FAIL wpc4_count: got %0d beats, required 20", got_n); end
        n_cmp++;
        if (got_i[4] !== 7'd16 || got_d[4] !== {32'hC2C4C700, 32'h0, 32'h30, 32'h85898E01}) begin
            n_err++;
            $display("FAIL wpc4_beat4: got idx=%0d data=%h, required 16 c2c4c700000000000000003085898e01", got_i[4], got_d[4]);
        end
        errs = 0;
        lasts = 0;
        for (int b = 0; b < 20; b++) begin
            e = {exp_q[4*b], exp_q[4*b+1], exp_q[4*b+2], exp_q[4*b+3]};
            if (got_d[b] !== e || got_i[b] !== 7'(4*b)) errs++;
            if (got_l[b] === 1'b1) lasts++;
        end
        n_cmp++;
        if (errs != 0) begin n_err++; $display("FAIL wpc4_stream: got %0d wrong beats, required 0", errs); end
        n_cmp++;
        if (lasts != 1 || got_l[19] !== 1'b1 || got_i[19] !== 7'd76) begin
            n_err++;
            $display("FAIL wpc4_last: got %0d last flags, final idx %0d, required 1 at idx 76", lasts, got_i[19]);
        end
        @(negedge clk);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        abc_blk = '0;
        abc_blk[511:480] = 32'h61626380;
        abc_blk[31:0]    = 32'h00000018;
        rst_n = 1'b0;
        flush1 = 1'b0; blk_valid1 = 1'b0; blk_data1 = '0; blk_sha0_1 = 1'b0; w_ready1 = 1'b0;
        flush4 = 1'b0; blk_valid4 = 1'b0; blk_data4 = '0; blk_sha0_4 = 1'b0; w_ready4 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        test_reset();
        @(negedge clk);
        test_sha1_abc();
        test_sha0_then_sha1();
        test_random_stall();
        test_back_to_back();
        test_abort(1'b0);
        test_abort(1'b1);
        test_wpc4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
